// File: rtl/ddrphy_pkg.sv
// Shared widths and write-path FSM encoding for the DDR2 PHY.
package ddrphy_pkg;

  localparam int DQ_WIDTH       = 64;
  localparam int DM_WIDTH       = 8;
  localparam int DFI_DATA_WIDTH = 128;
  localparam int DFI_MASK_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    POST = 2'd3
  } wr_state_t;

endpackage

// File: rtl/ddrphy_dly_line.sv
// Fixed-depth register delay with synchronous clear; exposes the final stage
// and the MSB of the stage before it as a one-cycle lookahead flag (DEPTH >= 2).
module ddrphy_dly_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_msb_nxt
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_d;
  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout         = stage_q[DEPTH-1];
  assign dout_msb_nxt = stage_q[DEPTH-2][WIDTH-1];

endmodule

// File: rtl/ddrphy_wr_path.sv
// DDR2 PHY write datapath: aligns DFI write data by WR_DELAY and emits
// per-phase DQ/DM/DQS with preamble, postamble and output enables.
module ddrphy_wr_path
  import ddrphy_pkg::*;
#(
  parameter int WR_DELAY = 2,
  parameter int BL       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wrdata_en,
  input  logic [DFI_DATA_WIDTH-1:0] wrdata,
  input  logic [DFI_MASK_WIDTH-1:0] wrdata_mask,
  output logic [DQ_WIDTH-1:0]       dq_rise,
  output logic [DQ_WIDTH-1:0]       dq_fall,
  output logic [DM_WIDTH-1:0]       dm_rise,
  output logic [DM_WIDTH-1:0]       dm_fall,
  output logic                      dq_oe,
  output logic                      dqs_rise,
  output logic                      dqs_fall,
  output logic                      dqs_oe,
  output logic                      wr_active,
  output logic                      wr_len_err
);

  localparam int PW   = 1 + DFI_MASK_WIDTH + DFI_DATA_WIDTH;
  localparam int HALF = BL / 2;

  logic [PW-1:0]             cur_word;
  logic                      nxt_en;
  logic                      cur_en;
  logic [DFI_MASK_WIDTH-1:0] cur_mask;
  logic [DFI_DATA_WIDTH-1:0] cur_data;

  ddrphy_dly_line #(
    .WIDTH (PW),
    .DEPTH (WR_DELAY)
  ) u_dly (
    .clk          (clk),
    .rst          (rst),
    .din          ({wrdata_en, wrdata_mask, wrdata}),
    .dout         (cur_word),
    .dout_msb_nxt (nxt_en)
  );

  assign cur_en   = cur_word[PW-1];
  assign cur_mask = cur_word[PW-2 -: DFI_MASK_WIDTH];
  assign cur_data = cur_word[DFI_DATA_WIDTH-1:0];

  wr_state_t           state_d, state_q;
  logic [DQ_WIDTH-1:0] dq_rise_d, dq_rise_q;
  logic [DQ_WIDTH-1:0] dq_fall_d, dq_fall_q;
  logic [DM_WIDTH-1:0] dm_rise_d, dm_rise_q;
  logic [DM_WIDTH-1:0] dm_fall_d, dm_fall_q;
  logic                dq_oe_d, dq_oe_q;
  logic                dqs_rise_d, dqs_rise_q;
  logic                dqs_oe_d, dqs_oe_q;
  logic [2:0]          cnt_d, cnt_q, cnt_inc;
  logic                err_d, err_q;

  // The stage on the pads this cycle decides DATA; the lookahead stage
  // decides whether a low DQS cycle is a preamble (shared with a postamble).
  always_comb begin
    state_d = IDLE;
    if (cur_en) begin
      state_d = DATA;
    end else if (nxt_en) begin
      state_d = PRE;
    end else if (state_q == DATA) begin
      state_d = POST;
    end

    dqs_oe_d   = (state_d != IDLE);
    dq_oe_d    = (state_d == DATA);
    dqs_rise_d = (state_d == DATA);
    dq_rise_d  = dq_oe_d ? cur_data[DFI_DATA_WIDTH-1 -: DQ_WIDTH] : '0;
    dq_fall_d  = dq_oe_d ? cur_data[DQ_WIDTH-1:0] : '0;
    dm_rise_d  = dq_oe_d ? cur_mask[DFI_MASK_WIDTH-1 -: DM_WIDTH] : '0;
    dm_fall_d  = dq_oe_d ? cur_mask[DM_WIDTH-1:0] : '0;
  end

  // Burst-length check runs on the raw input, independent of the delay line.
  always_comb begin
    cnt_inc = cnt_q + 3'd1;
    cnt_d   = 3'd0;
    if (wrdata_en) begin
      cnt_d = (cnt_inc == 3'(HALF)) ? 3'd0 : cnt_inc;
    end
    err_d = err_q | (!wrdata_en && (cnt_q != 3'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dq_rise_q  <= '0;
      dq_fall_q  <= '0;
      dm_rise_q  <= '0;
      dm_fall_q  <= '0;
      dq_oe_q    <= 1'b0;
      dqs_rise_q <= 1'b0;
      dqs_oe_q   <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dq_rise_q  <= dq_rise_d;
      dq_fall_q  <= dq_fall_d;
      dm_rise_q  <= dm_rise_d;
      dm_fall_q  <= dm_fall_d;
      dq_oe_q    <= dq_oe_d;
      dqs_rise_q <= dqs_rise_d;
      dqs_oe_q   <= dqs_oe_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign dq_rise    = dq_rise_q;
  assign dq_fall    = dq_fall_q;
  assign dm_rise    = dm_rise_q;
  assign dm_fall    = dm_fall_q;
  assign dq_oe      = dq_oe_q;
  assign dqs_rise   = dqs_rise_q;
  assign dqs_fall   = 1'b0;
  assign dqs_oe     = dqs_oe_q;
  assign wr_active  = dqs_oe_q;
  assign wr_len_err = err_q;

endmodule

// File: tb/tb_ddrphy_wr_path.sv
// Bench for ddrphy_wr_path: directed vector table, burst-shape sequences and
// randomized traffic checked against an input-history reference model.
module tb_ddrphy_wr_path;

  localparam int D    = 2;
  localparam int BLEN = 4;
  localparam int NH   = 2048;

  logic         clk;
  logic         rst;
  logic         wrdata_en;
  logic [127:0] wrdata;
  logic [15:0]  wrdata_mask;
  logic [63:0]  dq_rise, dq_fall;
  logic [7:0]   dm_rise, dm_fall;
  logic         dq_oe, dqs_rise, dqs_fall, dqs_oe, wr_active, wr_len_err;

  ddrphy_wr_path #(.WR_DELAY(D), .BL(BLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .wrdata_en   (wrdata_en),
    .wrdata      (wrdata),
    .wrdata_mask (wrdata_mask),
    .dq_rise     (dq_rise),
    .dq_fall     (dq_fall),
    .dm_rise     (dm_rise),
    .dm_fall     (dm_fall),
    .dq_oe       (dq_oe),
    .dqs_rise    (dqs_rise),
    .dqs_fall    (dqs_fall),
    .dqs_oe      (dqs_oe),
    .wr_active   (wr_active),
    .wr_len_err  (wr_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // History of every sampled input, indexed by clock edge.
  logic         h_en  [NH];
  logic [127:0] h_dat [NH];
  logic [15:0]  h_msk [NH];
  int           cyc      = -1;
  int           last_rst = -1;
  int           run_len  = 0;
  logic         m_err    = 1'b0;

  int   mon_dq, mon_dqs, mon_rise, mon_low;
  logic prev_oe = 1'b0;

  function automatic logic eff(int j);
    if (j < 0 || j <= last_rst) return 1'b0;
    return h_en[j];
  endfunction

  function automatic logic [149:0] actual_vec();
    return {dq_rise, dq_fall, dm_rise, dm_fall, dq_oe, dqs_rise, dqs_fall, dqs_oe, wr_active, wr_len_err};
  endfunction

  // Pads carry the word sampled D edges ago; the low DQS cycle before it is
  // a preamble, the one after the last data word a postamble.
  function automatic logic [149:0] model_vec(int k);
    logic d, p, q, oe;
    logic [63:0] r, f;
    logic [7:0] mr, mf;
    d  = eff(k - D);
    p  = eff(k - D + 1);
    q  = eff(k - D - 1);
    oe = d | p | q;
    r = '0; f = '0; mr = '0; mf = '0;
    if (d) begin
      r  = h_dat[k-D][127:64];
      f  = h_dat[k-D][63:0];
      mr = h_msk[k-D][15:8];
      mf = h_msk[k-D][7:0];
    end
    return {r, f, mr, mf, d, d, 1'b0, oe, oe, m_err};
  endfunction

  task automatic check(input string name, input logic [149:0] act, input logic [149:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic mon_clear();
    mon_dq = 0; mon_dqs = 0; mon_rise = 0; mon_low = 0;
  endtask

  task automatic step(input logic r, input logic e, input logic [127:0] dat, input logic [15:0] m);
    rst = r; wrdata_en = e; wrdata = dat; wrdata_mask = m;
    @(posedge clk);
    cyc++;
    if (cyc >= NH) begin
      $display("FAIL history_overflow cyc=%0d got=%0d exp=<%0d", cyc, cyc, NH);
      $fatal(1, "history overflow");
    end
    h_en[cyc] = e; h_dat[cyc] = dat; h_msk[cyc] = m;
    if (r) begin
      last_rst = cyc; run_len = 0; m_err = 1'b0;
    end else if (e) begin
      run_len++;
    end else begin
      if (run_len % (BLEN / 2) != 0) m_err = 1'b1;
      run_len = 0;
    end
    #1;
    check("model", actual_vec(), model_vec(cyc));
    mon_dq   += int'(dq_oe);
    mon_dqs  += int'(dqs_oe);
    mon_rise += int'(dqs_oe && !prev_oe);
    mon_low  += int'(dqs_oe && !dqs_rise);
    prev_oe   = dqs_oe;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic en_seq(input logic [15:0] pat, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      step(1'b0, pat[i], {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
    end
  endtask

  typedef struct {
    logic r; logic e; logic [127:0] d; logic [15:0] m;
    logic x_dqs_oe; logic x_dqs_rise; logic x_dq_oe;
    logic [63:0] x_dq_rise; logic [63:0] x_dq_fall;
    logic [7:0] x_dm_rise; logic [7:0] x_dm_fall; logic x_err;
  } vec_t;

  vec_t tbl[17];

  localparam logic [127:0] WA  = {32{4'hA}};
  localparam logic [127:0] W5  = {32{4'h5}};
  localparam logic [127:0] W10 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
  localparam logic [127:0] W11 = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
  localparam logic [127:0] W12 = {64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002};

  initial begin
    rst = 1'b1; wrdata_en = 1'b0; wrdata = '0; wrdata_mask = '0;

    tbl[0]  = '{1'b1, 1'b0, '0,  16'h0,    1'b0, 1'b0, 1'b0, '0, '0, 8'h0, 8'h0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, '0,  16'h0,    1'b0, 1'b0, 1'b0, '0, '0, 8'h0, 8'h0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, '0,  16'h0,    1'b0, 1'b0, 1'b0, '0, '0, 8'h0, 8'h0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, '0,  16'h0,    1'b0, 1'b0, 1'b0, '0, '0, 8'h0, 8'h0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, WA,  16'h0,    1'b0, 1'b0, 1'b0, '0, '0, 8'h0, 8'h0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, W5,  16'hF00F, 1'b1, 1'b0, 1'b0, '0, '0, 8'h0, 8'h0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, '0,  16'h0,    1'b1, 1'b1, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0, 8'h0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, '0,  16'h0,    1'b1, 1'b1, 1'b1, 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 8'hF0, 8'h0F, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, '0,  16'h0,    1'b1, 1'b0, 1'b0, '0, '0, 8'h0, 8'h0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, '0,  16'h0,    1'b0, 1'b0, 1'b0, '0, '0, 8'h0, 8'h0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, W10, 16'h0,    1'b0, 1'b0, 1'b0, '0, '0, 8'h0, 8'h0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, W11, 16'h0,    1'b1, 1'b0, 1'b0, '0, '0, 8'h0, 8'h0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, W12, 16'h0,    1'b1, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 8'h0, 8'h0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, '0,  16'h0,    1'b1, 1'b1, 1'b1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 8'h0, 8'h0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, '0,  16'h0,    1'b1, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002, 8'h0, 8'h0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, '0,  16'h0,    1'b1, 1'b0, 1'b0, '0, '0, 8'h0, 8'h0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, '0,  16'h0,    1'b0, 1'b0, 1'b0, '0, '0, 8'h0, 8'h0, 1'b1};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].m);
      check($sformatf("vec%0d", i), actual_vec(),
            {tbl[i].x_dq_rise, tbl[i].x_dq_fall, tbl[i].x_dm_rise, tbl[i].x_dm_fall,
             tbl[i].x_dq_oe, tbl[i].x_dqs_rise, 1'b0, tbl[i].x_dqs_oe, tbl[i].x_dqs_oe, tbl[i].x_err});
    end

    // Error flag is sticky until reset.
    idle(3);
    check_int("err_sticky", int'(wr_len_err), 1);
    step(1'b1, 1'b0, '0, '0);
    check_int("err_cleared", int'(wr_len_err), 0);
    idle(2);

    // Back-to-back: two BL4 bursts with no gap.
    mon_clear();
    en_seq(16'b1111, 4);
    idle(5);
    check_int("b2b_data", mon_dq, 4);
    check_int("b2b_dqs", mon_dqs, 6);
    check_int("b2b_contig", mon_rise, 1);
    check_int("b2b_low", mon_low, 2);
    check_int("b2b_noerr", int'(wr_len_err), 0);

    // One-cycle gap: a single shared low DQS cycle, enable never drops.
    mon_clear();
    en_seq(16'b11011, 5);
    idle(5);
    check_int("gap1_data", mon_dq, 4);
    check_int("gap1_dqs", mon_dqs, 7);
    check_int("gap1_contig", mon_rise, 1);
    check_int("gap1_low", mon_low, 3);

    // Three-cycle gap: post, idle, pre.
    mon_clear();
    en_seq(16'b1100011, 7);
    idle(5);
    check_int("gap3_data", mon_dq, 4);
    check_int("gap3_dqs", mon_dqs, 8);
    check_int("gap3_windows", mon_rise, 2);

    // Reset in the first DATA cycle kills the burst with no postamble.
    idle(3);
    en_seq(16'b11, 2);
    step(1'b0, 1'b0, '0, '0);
    check_int("mid_in_data", int'(dq_oe), 1);
    mon_clear();
    step(1'b1, 1'b0, '0, '0);
    check("mid_rst_zero", actual_vec(), '0);
    idle(5);
    check_int("mid_no_post", mon_dqs, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 99) < 55),
           {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
